// File: rtl/mmio_bus_master.sv
// mmio_bus_master: initiator side of the word-addressed peripheral bus.
// Takes one load/store request at a time and decodes it to DMEM or TIMER.
// It drives the selected slave and waits out the slave read latency.
// It returns one response pulse per request.
// Optional build macro: MISALIGN_TRAP_EN. When it is defined, misaligned
// half/word accesses take the error path. When it is undefined, the address
// bits [1:0] are ignored.
module mmio_bus_master #(
    parameter logic [31:0] DMEM_BASE  = 32'h0000_0000,
    parameter logic [31:0] TIMER_BASE = 32'h0000_1000,
    parameter int          READ_LAT   = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_ld,
    input  logic [2:0]  req_st,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [9:0]  A,
    output logic [31:0] WD,
    output logic        WE,
    output logic [2:0]  load_choice,
    output logic [2:0]  sw_choice,
    output logic        sel_dmem,
    output logic        sel_timer,
    input  logic [31:0] rd_dmem,
    input  logic [31:0] rd_timer
);

    // Load/store operation codes as seen on the bus.
    localparam logic [2:0] LD_LB  = 3'b001;
    localparam logic [2:0] LD_LBU = 3'b010;
    localparam logic [2:0] LD_LH  = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b100;
    localparam logic [2:0] LD_LW  = 3'b111;
    localparam logic [2:0] ST_SB  = 3'b001;
    localparam logic [2:0] ST_SH  = 3'b010;
    localparam logic [2:0] ST_SW  = 3'b011;

    // WAIT lasts READ_LAT cycles. The counter starts at READ_LAT-1 and the
    // slave data is sampled when the counter reaches zero.
    localparam logic [1:0] CNT_INIT = 2'(READ_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    function automatic logic ld_code_ok(input logic [2:0] code);
        logic ok;
        case (code)
            LD_LB, LD_LBU, LD_LH, LD_LHU, LD_LW: ok = 1'b1;
            default:                             ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic st_code_ok(input logic [2:0] code);
        logic ok;
        case (code)
            ST_SB, ST_SH, ST_SW: ok = 1'b1;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t      state_q, state_d;
    logic [9:0]  word_q, word_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  ld_q, ld_d;
    logic [2:0]  st_q, st_d;
    logic        tgt_dmem_q, tgt_dmem_d;
    logic        tgt_timer_q, tgt_timer_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  cnt_q, cnt_d;

    logic hit_dmem;
    logic hit_timer;
    logic code_ok;
    logic misalign;
    logic req_err;
    logic bus_phase;

`ifdef MISALIGN_TRAP_EN
    // Flag half-word and word accesses whose byte offset breaks natural alignment.
    always_comb begin
        misalign = 1'b0;
        if (req_we) begin
            case (req_st)
                ST_SH:   misalign = req_addr[0];
                ST_SW:   misalign = |req_addr[1:0];
                default: misalign = 1'b0;
            endcase
        end else begin
            case (req_ld)
                LD_LH, LD_LHU: misalign = req_addr[0];
                LD_LW:         misalign = |req_addr[1:0];
                default:       misalign = 1'b0;
            endcase
        end
    end
`else
    // The byte offset plays no part: the access goes to word addr[11:2].
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = &{1'b0, req_addr[1:0]};
    assign misalign         = 1'b0;
`endif

    // Decode the window and check the request. DMEM has priority, so the
    // selects stay one-hot even if both bases are set to the same window.
    always_comb begin
        hit_dmem  = (req_addr[31:12] == DMEM_BASE[31:12]);
        hit_timer = !hit_dmem && (req_addr[31:12] == TIMER_BASE[31:12]);
        code_ok   = req_we ? st_code_ok(req_st) : ld_code_ok(req_ld);
        req_err   = !(hit_dmem || hit_timer) || !code_ok || misalign;
    end

    // Next-state logic for the transaction sequencer and the request/response registers.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        ld_d        = ld_q;
        st_d        = st_q;
        tgt_dmem_d  = tgt_dmem_q;
        tgt_timer_d = tgt_timer_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    word_d  = req_addr[11:2];
                    we_d    = req_we;
                    wdata_d = req_we ? req_wdata : 32'h0;
                    ld_d    = req_we ? 3'b000 : req_ld;
                    st_d    = req_we ? req_st : 3'b000;
                    rdata_d = 32'h0;
                    err_d   = req_err;
                    if (req_err) begin
                        // Errors never reach the bus: no select is recorded.
                        tgt_dmem_d  = 1'b0;
                        tgt_timer_d = 1'b0;
                        state_d     = S_RESP;
                    end else begin
                        tgt_dmem_d  = hit_dmem;
                        tgt_timer_d = hit_timer;
                        state_d     = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                if (we_q) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (cnt_q == 2'd0) begin
                    rdata_d = tgt_dmem_q ? rd_dmem : rd_timer;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and request registers. Reset aborts any transaction in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            word_q      <= 10'h0;
            we_q        <= 1'b0;
            wdata_q     <= 32'h0;
            ld_q        <= 3'b000;
            st_q        <= 3'b000;
            tgt_dmem_q  <= 1'b0;
            tgt_timer_q <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'h0;
            cnt_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            ld_q        <= ld_d;
            st_q        <= st_d;
            tgt_dmem_q  <= tgt_dmem_d;
            tgt_timer_q <= tgt_timer_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
        end
    end

    // Bus and response outputs, decoded from the registered state only.
    // All bus signals are zero outside ISSUE/WAIT. The write strobe lives in
    // ISSUE only and always comes with exactly one select.
    always_comb begin
        bus_phase   = (state_q == S_ISSUE) || (state_q == S_WAIT);
        req_ready   = (state_q == S_IDLE);
        sel_dmem    = bus_phase && tgt_dmem_q;
        sel_timer   = bus_phase && tgt_timer_q;
        A           = bus_phase ? word_q : 10'h0;
        WE          = (state_q == S_ISSUE) && we_q && (tgt_dmem_q ^ tgt_timer_q);
        WD          = ((state_q == S_ISSUE) && we_q) ? wdata_q : 32'h0;
        load_choice = (bus_phase && !we_q) ? ld_q : 3'b000;
        sw_choice   = ((state_q == S_ISSUE) && we_q) ? st_q : 3'b000;
        rsp_valid   = (state_q == S_RESP);
        rsp_err     = (state_q == S_RESP) && err_q;
        rsp_rdata   = (state_q == S_RESP) ? rdata_q : 32'h0;
    end

endmodule

// File: tb/tb_mmio_bus_master.sv
// Scoreboard bench for mmio_bus_master. The stimulus pushes the expected
// response and the expected bus cycles into queues. The monitors pop and
// compare those entries on the falling edge.
module tb_mmio_bus_master;

    localparam int RL = 1;

    logic        CLK;
    logic        RST;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [31:0] req_wdata;
    logic [2:0]  req_ld;
    logic [2:0]  req_st;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [9:0]  A;
    logic [31:0] WD;
    logic        WE;
    logic [2:0]  load_choice;
    logic [2:0]  sw_choice;
    logic        sel_dmem;
    logic        sel_timer;
    logic [31:0] rd_dmem;
    logic [31:0] rd_timer;

    mmio_bus_master #(
        .DMEM_BASE (32'h0000_0000),
        .TIMER_BASE(32'h0000_1000),
        .READ_LAT  (RL)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_we     (req_we),
        .req_wdata  (req_wdata),
        .req_ld     (req_ld),
        .req_st     (req_st),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .A          (A),
        .WD         (WD),
        .WE         (WE),
        .load_choice(load_choice),
        .sw_choice  (sw_choice),
        .sel_dmem   (sel_dmem),
        .sel_timer  (sel_timer),
        .rd_dmem    (rd_dmem),
        .rd_timer   (rd_timer)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } rsp_t;

    rsp_t        rsp_q[$];
    logic [50:0] bus_q[$];
    int          n_vec  = 0;
    int          n_fail = 0;
    int          cyc    = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [50:0] mk_bus(input logic sd, input logic st, input logic [9:0] a,
                                           input logic we, input logic [31:0] wd,
                                           input logic [2:0] lc, input logic [2:0] sc);
        return {sd, st, a, we, wd, lc, sc};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Bus monitor: every cycle that shows any bus activity must match the next expected bus cycle.
    always @(negedge CLK) begin
        if (!RST) begin
            if (sel_dmem && sel_timer) chk("sel_onehot", {sel_dmem, sel_timer}, 64'h0);
            if (WE) chk("we_one_sel", 64'(sel_dmem ^ sel_timer), 64'h1);
            if (sel_dmem || sel_timer || WE || A != 10'h0 || WD != 32'h0 ||
                load_choice != 3'b000 || sw_choice != 3'b000) begin
                if (bus_q.size() == 0) begin
                    chk("unexpected_bus", 64'(mk_bus(sel_dmem, sel_timer, A, WE, WD, load_choice, sw_choice)), 64'h0);
                end else begin
                    chk("bus_cycle", 64'(mk_bus(sel_dmem, sel_timer, A, WE, WD, load_choice, sw_choice)),
                        64'(bus_q.pop_front()));
                end
            end
        end
    end

    // Response monitor: each rsp_valid pulse is checked against the next expected response.
    always @(negedge CLK) begin
        if (!RST && rsp_valid) begin
            if (rsp_q.size() == 0) begin
                chk("unexpected_rsp", {31'h0, rsp_err, rsp_rdata}, 64'h0);
            end else begin
                rsp_t e;
                e = rsp_q.pop_front();
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                chk("rsp_err", 64'(rsp_err), 64'(e.err));
                chk("rsp_latency", 64'(cyc - e.acc + 1), 64'(e.lat));
                $display("rsp: rdata=%h err=%0d lat=%0d", rsp_rdata, rsp_err, cyc - e.acc + 1);
            end
        end
    end

    // Issue one request, queue its expected bus cycles and response, and wait until it drains.
    // sel: 2'b01 = DMEM, 2'b10 = TIMER (ignored for errors).
    // With abort set, reset is pulsed during WAIT and no response is expected.
    task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] ld, input logic [2:0] st,
                          input logic [31:0] rdd, input logic [31:0] rdt, input logic err,
                          input logic [1:0] sel, input logic [9:0] a,
                          input logic [31:0] exp_rdata, input logic abort);
        int   n;
        rsp_t r;
        @(posedge CLK);
        #1;
        rd_dmem   = rdd;
        rd_timer  = rdt;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_ld    = ld;
        req_st    = st;
        req_valid = 1'b1;
        n = 0;
        @(negedge CLK);
        while (!req_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (!req_ready) begin
            chk({name, "_accept_timeout"}, 64'(req_ready), 64'h1);
            req_valid = 1'b0;
            return;
        end
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        if (!err) begin
            if (we) begin
                bus_q.push_back(mk_bus(sel[0], sel[1], a, 1'b1, wdata, 3'b000, st));
            end else begin
                for (int i = 0; i < 1 + RL; i++)
                    bus_q.push_back(mk_bus(sel[0], sel[1], a, 1'b0, 32'h0, ld, 3'b000));
            end
        end
        r.rdata = (we || err) ? 32'h0 : exp_rdata;
        r.err   = err;
        r.lat   = err ? 1 : (we ? 2 : 2 + RL);
        r.acc   = cyc;
        $display("req %s: we=%0d addr=%h wdata=%h ld=%b st=%b exp_err=%0d exp_rdata=%h",
                 name, we, addr, wdata, ld, st, err, r.rdata);
        if (abort) begin
            for (int i = 0; i < 1 + RL; i++) @(negedge CLK);
            #1 RST = 1'b1;
            @(posedge CLK);
            #1 RST = 1'b0;
            @(negedge CLK);
            chk({name, "_idle_after_rst"}, 64'(req_ready), 64'h1);
            repeat (3) @(negedge CLK);
        end else begin
            rsp_q.push_back(r);
            n = 0;
            do begin
                @(negedge CLK);
                n++;
            end while (!req_ready && n < 50);
            if (!req_ready) chk({name, "_done_timeout"}, 64'(req_ready), 64'h1);
        end
    endtask

    initial begin
        RST       = 1'b1;
        req_valid = 1'b0;
        req_addr  = 32'h0;
        req_we    = 1'b0;
        req_wdata = 32'h0;
        req_ld    = 3'b000;
        req_st    = 3'b000;
        rd_dmem   = 32'h0;
        rd_timer  = 32'h0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset_req_ready", 64'(req_ready), 64'h1);
        chk("reset_ctrl", {59'h0, rsp_valid, rsp_err, WE, sel_dmem, sel_timer}, 64'h0);
        chk("reset_A_codes", {48'h0, A, load_choice, sw_choice}, 64'h0);
        chk("reset_WD", 64'(WD), 64'h0);
        chk("reset_rdata", 64'(rsp_rdata), 64'h0);
        #1 RST = 1'b0;

        do_req("sw_dmem", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3'b000, 3'b011,
               32'h0, 32'h0, 1'b0, 2'b01, 10'd4, 32'h0, 1'b0);
        do_req("lb_timer", 1'b0, 32'h0000_1008, 32'h0, 3'b001, 3'b000,
               32'h1111_1111, 32'hFFFF_FF80, 1'b0, 2'b10, 10'd2, 32'hFFFF_FF80, 1'b0);
        do_req("lw_unmapped", 1'b0, 32'h0000_2000, 32'h0, 3'b111, 3'b000,
               32'h2222_2222, 32'h3333_3333, 1'b1, 2'b00, 10'd0, 32'h0, 1'b0);
`ifdef MISALIGN_TRAP_EN
        do_req("lw_misalign", 1'b0, 32'h0000_0006, 32'h0, 3'b111, 3'b000,
               32'hCAFE_F00D, 32'h0, 1'b1, 2'b00, 10'd0, 32'h0, 1'b0);
        do_req("lh_misalign", 1'b0, 32'h0000_1001, 32'h0, 3'b011, 3'b000,
               32'h0, 32'hFFFF_8001, 1'b1, 2'b00, 10'd0, 32'h0, 1'b0);
        do_req("sw_misalign", 1'b1, 32'h0000_1006, 32'h1357_9BDF, 3'b000, 3'b011,
               32'h0, 32'h0, 1'b1, 2'b00, 10'd0, 32'h0, 1'b0);
`else
        do_req("lw_misalign", 1'b0, 32'h0000_0006, 32'h0, 3'b111, 3'b000,
               32'hCAFE_F00D, 32'h0, 1'b0, 2'b01, 10'd1, 32'hCAFE_F00D, 1'b0);
        do_req("lh_misalign", 1'b0, 32'h0000_1001, 32'h0, 3'b011, 3'b000,
               32'h0, 32'hFFFF_8001, 1'b0, 2'b10, 10'd0, 32'hFFFF_8001, 1'b0);
        do_req("sw_misalign", 1'b1, 32'h0000_1006, 32'h1357_9BDF, 3'b000, 3'b011,
               32'h0, 32'h0, 1'b0, 2'b10, 10'd1, 32'h0, 1'b0);
`endif
        do_req("ld_code_101", 1'b0, 32'h0000_0004, 32'h0, 3'b101, 3'b000,
               32'h4444_4444, 32'h0, 1'b1, 2'b00, 10'd0, 32'h0, 1'b0);
        do_req("ld_code_000", 1'b0, 32'h0000_0004, 32'h0, 3'b000, 3'b000,
               32'h4444_4444, 32'h0, 1'b1, 2'b00, 10'd0, 32'h0, 1'b0);
        do_req("st_code_100", 1'b1, 32'h0000_0004, 32'h5555_5555, 3'b000, 3'b100,
               32'h0, 32'h0, 1'b1, 2'b00, 10'd0, 32'h0, 1'b0);
        do_req("sh_timer", 1'b1, 32'h0000_1002, 32'h0000_1234, 3'b000, 3'b010,
               32'h0, 32'h0, 1'b0, 2'b10, 10'd0, 32'h0, 1'b0);
        do_req("lhu_dmem_top", 1'b0, 32'h0000_0FFC, 32'h0, 3'b100, 3'b000,
               32'h0000_BEEF, 32'h6666_6666, 1'b0, 2'b01, 10'h3FF, 32'h0000_BEEF, 1'b0);
        do_req("sb_dmem_top", 1'b1, 32'h0000_0FFF, 32'h0000_00AB, 3'b000, 3'b001,
               32'h0, 32'h0, 1'b0, 2'b01, 10'h3FF, 32'h0, 1'b0);
        do_req("lbu_timer_top", 1'b0, 32'h0000_1FFC, 32'h0, 3'b010, 3'b000,
               32'h7777_7777, 32'h0000_007F, 1'b0, 2'b10, 10'h3FF, 32'h0000_007F, 1'b0);
        do_req("lw_high_addr", 1'b0, 32'hFFFF_F000, 32'h0, 3'b111, 3'b000,
               32'h8888_8888, 32'h9999_9999, 1'b1, 2'b00, 10'd0, 32'h0, 1'b0);
        do_req("lw_abort", 1'b0, 32'h0000_0020, 32'h0, 3'b111, 3'b000,
               32'hAAAA_AAAA, 32'h0, 1'b0, 2'b01, 10'd8, 32'hAAAA_AAAA, 1'b1);
        do_req("lw_after_rst", 1'b0, 32'h0000_1010, 32'h0, 3'b111, 3'b000,
               32'h0, 32'h5A5A_5A5A, 1'b0, 2'b10, 10'd4, 32'h5A5A_5A5A, 1'b0);

        repeat (4) @(negedge CLK);
        chk("rsp_queue_drained", 64'(rsp_q.size()), 64'h0);
        chk("bus_queue_drained", 64'(bus_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
